// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//   Word-level front end for a serial "101" Moore detector (overlapping).
//   Parallel words arrive over a valid/ready handshake, are serialized
//   MSB-first into the embedded detector at one bit per cycle, and the number
//   of matches completed within each word is reported with a one-cycle pulse.
//   A running total of matches is kept and can be cleared by software.
//
//   Optional feature macro: SEQ_CTRL_SAT_EN
//     defined   -> total_cnt saturates at 2**CNT_W-1
//     undefined -> total_cnt wraps modulo 2**CNT_W (default build)
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    input  logic                         clr_total,
    output logic                         busy,
    output logic                         bit_o,
    output logic                         det_o,
    output logic                         res_valid,
    output logic [$clog2(DATA_W+1)-1:0]  res_count,
    output logic [CNT_W-1:0]             total_cnt
);

    // Width of the per-word match counter and of the bit index.
    localparam int RC_W  = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(DATA_W + 1);

    // Index value of the final bit of a word; its edge ends the SHIFT phase.
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TOTAL_MAX = {CNT_W{1'b1}};

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_REPORT = 2'b10
    } ctrl_state_t;

    // Detector states, named after the suffix matched so far.
    typedef enum logic [1:0] {
        D_S0   = 2'b00,
        D_S1   = 2'b01,
        D_S10  = 2'b10,
        D_S101 = 2'b11
    } det_state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    ctrl_state_t        ctrl_r;
    ctrl_state_t        ctrl_nxt_s;
    det_state_t         det_r;
    det_state_t         det_nxt_s;

    logic [DATA_W-1:0]  shreg_r;
    logic [IDX_W-1:0]   idx_r;
    logic [RC_W-1:0]    wcnt_r;
    logic [RC_W-1:0]    wcnt_inc_s;
    logic [RC_W-1:0]    res_count_r;
    logic [CNT_W-1:0]   total_r;
    logic [CNT_W-1:0]   total_inc_s;

    logic               accept_s;
    logic               shift_s;
    logic               last_bit_s;
    logic               match_s;

    logic               in_ready_nxt_s;
    logic               busy_nxt_s;
    logic               res_valid_nxt_s;
    logic               det_o_nxt_s;

    logic               in_ready_r;
    logic               busy_r;
    logic               res_valid_r;
    logic               det_o_r;

    // -------------------------------------------------------------------------
    // Qualifiers shared by the FSMs and the datapath
    // -------------------------------------------------------------------------

    // Decode handshake acceptance, shift activity, last bit and a new match.
    always_comb begin
        accept_s   = (ctrl_r == ST_IDLE) && in_valid;
        shift_s    = (ctrl_r == ST_SHIFT);
        last_bit_s = shift_s && (idx_r == LAST_IDX);
        match_s    = shift_s && (det_nxt_s == D_S101);
    end

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_r <= ST_IDLE;
        end else begin
            ctrl_r <= ctrl_nxt_s;
        end
    end

    // Controller next state: accept in IDLE, DATA_W shift cycles, one report cycle.
    always_comb begin
        ctrl_nxt_s = ctrl_r;
        case (ctrl_r)
            ST_IDLE: begin
                if (in_valid) begin
                    ctrl_nxt_s = ST_SHIFT;
                end else begin
                    ctrl_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (idx_r == LAST_IDX) begin
                    ctrl_nxt_s = ST_REPORT;
                end else begin
                    ctrl_nxt_s = ST_SHIFT;
                end
            end
            ST_REPORT: begin
                ctrl_nxt_s = ST_IDLE;
            end
            default: begin
                ctrl_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller outputs decoded from the next state so they can be registered.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        busy_nxt_s      = 1'b0;
        res_valid_nxt_s = 1'b0;
        case (ctrl_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s = 1'b1;
            end
            ST_SHIFT: begin
                busy_nxt_s = 1'b1;
            end
            ST_REPORT: begin
                busy_nxt_s      = 1'b1;
                res_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Detector FSM (Moore, overlapping "101")
    // -------------------------------------------------------------------------

    // Detector state register; holds outside SHIFT via the next-state logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            det_r <= D_S0;
        end else begin
            det_r <= det_nxt_s;
        end
    end

    // Detector next state: consume bit_o only on SHIFT edges.
    always_comb begin
        det_nxt_s = det_r;
        if (shift_s) begin
            case (det_r)
                D_S0:    det_nxt_s = bit_o ? D_S1   : D_S0;
                D_S1:    det_nxt_s = bit_o ? D_S1   : D_S10;
                D_S10:   det_nxt_s = bit_o ? D_S101 : D_S0;
                D_S101:  det_nxt_s = bit_o ? D_S1   : D_S10;
                default: det_nxt_s = D_S0;
            endcase
        end else begin
            det_nxt_s = det_r;
        end
    end

    // Detector output decoded from its next state so det_o is a flop.
    always_comb begin
        case (det_nxt_s)
            D_S101:  det_o_nxt_s = 1'b1;
            default: det_o_nxt_s = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------

    // Output flops; in_ready comes out of reset high because IDLE accepts.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            det_o_r     <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            busy_r      <= busy_nxt_s;
            res_valid_r <= res_valid_nxt_s;
            det_o_r     <= det_o_nxt_s;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------

    // Shift register: load on accept, shift left (zero fill) on every SHIFT edge.
    // After the last shift it is all zeros, so bit_o idles low.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_r <= '0;
        end else if (accept_s) begin
            shreg_r <= in_data;
        end else if (shift_s) begin
            shreg_r <= shreg_r << 1;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Bit index within the current word.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r <= '0;
        end else if (accept_s) begin
            idx_r <= '0;
        end else if (shift_s) begin
            idx_r <= idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Incremented word count, used both for the counter and the result capture.
    always_comb begin
        wcnt_inc_s = wcnt_r + RC_W'(1);
    end

    // Matches completed within the current word; cleared when a word is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_r <= '0;
        end else if (accept_s) begin
            wcnt_r <= '0;
        end else if (match_s) begin
            wcnt_r <= wcnt_inc_s;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Result capture on the last bit edge, including a match on that very bit;
    // the value is held until the next word reports.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_count_r <= '0;
        end else if (last_bit_s) begin
            res_count_r <= match_s ? wcnt_inc_s : wcnt_r;
        end else begin
            res_count_r <= res_count_r;
        end
    end

    // Running-total increment: saturating or wrapping depending on the build.
    always_comb begin
`ifdef SEQ_CTRL_SAT_EN
        if (total_r == TOTAL_MAX) begin
            total_inc_s = total_r;
        end else begin
            total_inc_s = total_r + CNT_W'(1);
        end
`else
        total_inc_s = total_r + CNT_W'(1);
`endif
    end

    // Running total; a clear wins over a coincident match, which is then lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            total_r <= '0;
        end else if (clr_total) begin
            total_r <= '0;
        end else if (match_s) begin
            total_r <= total_inc_s;
        end else begin
            total_r <= total_r;
        end
    end

    // -------------------------------------------------------------------------
    // Port drives (all straight from flops)
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign bit_o     = shreg_r[DATA_W-1];
    assign det_o     = det_o_r;
    assign res_valid = res_valid_r;
    assign res_count = res_count_r;
    assign total_cnt = total_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Directed bench for seq_detect_ctrl. A default instance (CNT_W=8) is checked
//   in every scenario; a second instance with CNT_W=3 shares the stimulus and
//   is checked for total-counter wrap/saturation.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr_total;

    logic       in_ready;
    logic       busy;
    logic       bit_o;
    logic       det_o;
    logic       res_valid;
    logic [3:0] res_count;
    logic [7:0] total_cnt;

    logic       in_ready_3;
    logic       busy_3;
    logic       bit_o_3;
    logic       det_o_3;
    logic       res_valid_3;
    logic [3:0] res_count_3;
    logic [2:0] total_cnt_3;

    int n_tests;
    int n_fail;

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr_total (clr_total),
        .busy      (busy),
        .bit_o     (bit_o),
        .det_o     (det_o),
        .res_valid (res_valid),
        .res_count (res_count),
        .total_cnt (total_cnt)
    );

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(3)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_3),
        .clr_total (clr_total),
        .busy      (busy_3),
        .bit_o     (bit_o_3),
        .det_o     (det_o_3),
        .res_valid (res_valid_3),
        .res_count (res_count_3),
        .total_cnt (total_cnt_3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        clr_total = 1'b0;
        in_data   = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    // Accept one word and run to the REPORT cycle (ends just after edge E8).
    task automatic run_word(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        clr_total = 1'b0;
        in_data   = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_tests++; if (bit_o !== 1'b0) begin n_fail++; $display("FAIL rst_bit_o: got %b expected 0", bit_o); end
        n_tests++; if (det_o !== 1'b0) begin n_fail++; $display("FAIL rst_det_o: got %b expected 0", det_o); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
        n_tests++; if (res_count !== 4'd0) begin n_fail++; $display("FAIL rst_res_count: got %0d expected 0", res_count); end
        n_tests++; if (total_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_total: got %0d expected 0", total_cnt); end
    endtask

    // 0xAB: bits 1,0,1,0,1,0,1,1 -> three matches, det_o after E3, E5, E7.
    task automatic test_pattern_ab();
        logic [7:0] bits;
        logic [7:0] dets;
        int         rv_early;
        do_reset();
        in_data  = 8'hAB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ab_busy: got %b expected 1", busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ab_in_ready: got %b expected 0", in_ready); end
        bits = 8'h00;
        dets = 8'h00;
        rv_early = 0;
        for (int k = 0; k < 8; k++) begin
            bits[7-k] = bit_o;
            tick();
            dets[7-k] = det_o;
            if (k < 7 && res_valid === 1'b1) rv_early++;
        end
        n_tests++; if (bits !== 8'hAB) begin n_fail++; $display("FAIL ab_bits: got %h expected ab", bits); end
        n_tests++; if (dets !== 8'b0010_1010) begin n_fail++; $display("FAIL ab_det_seq: got %b expected 00101010", dets); end
        n_tests++; if (rv_early !== 0) begin n_fail++; $display("FAIL ab_res_valid_early: got %0d expected 0", rv_early); end
        n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL ab_res_valid: got %b expected 1", res_valid); end
        n_tests++; if (res_count !== 4'd3) begin n_fail++; $display("FAIL ab_res_count: got %0d expected 3", res_count); end
        n_tests++; if (total_cnt !== 8'd3) begin n_fail++; $display("FAIL ab_total: got %0d expected 3", total_cnt); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ab_report_ready: got %b expected 0", in_ready); end
        tick();
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ab_res_valid_pulse: got %b expected 0", res_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ab_idle_ready: got %b expected 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle_busy: got %b expected 0", busy); end
        n_tests++; if (res_count !== 4'd3) begin n_fail++; $display("FAIL ab_res_hold: got %0d expected 3", res_count); end
    endtask

    // 0x02 leaves the detector in S10; the first bit of 0x80 completes a match.
    task automatic test_boundary();
        do_reset();
        run_word(8'h02);
        n_tests++; if (res_count !== 4'd0) begin n_fail++; $display("FAIL bnd_w1_count: got %0d expected 0", res_count); end
        tick();
        in_data  = 8'h80;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_tests++; if (det_o !== 1'b1) begin n_fail++; $display("FAIL bnd_det_first_bit: got %b expected 1", det_o); end
        repeat (7) tick();
        n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bnd_w2_valid: got %b expected 1", res_valid); end
        n_tests++; if (res_count !== 4'd1) begin n_fail++; $display("FAIL bnd_w2_count: got %0d expected 1", res_count); end
        n_tests++; if (total_cnt !== 8'd1) begin n_fail++; $display("FAIL bnd_total: got %0d expected 1", total_cnt); end
        tick();
    endtask

    // in_valid held with 0x55: accepts 10 cycles apart, counts 3 then 4.
    task automatic test_back_to_back();
        int       acc_cyc[2];
        int       rc[2];
        int       n_acc;
        int       n_res;
        logic     acc;
        do_reset();
        n_acc = 0;
        n_res = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        rc[0] = -1; rc[1] = -1;
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                if (n_acc < 2) acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == 2) in_valid = 1'b0;
            end
            if (res_valid === 1'b1) begin
                if (n_res < 2) rc[n_res] = int'(res_count);
                n_res++;
            end
        end
        n_tests++; if (n_acc !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
        n_tests++; if (acc_cyc[1] - acc_cyc[0] !== 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 10", acc_cyc[1] - acc_cyc[0]); end
        n_tests++; if (n_res !== 2) begin n_fail++; $display("FAIL b2b_reports: got %0d expected 2", n_res); end
        n_tests++; if (rc[0] !== 3) begin n_fail++; $display("FAIL b2b_count1: got %0d expected 3", rc[0]); end
        n_tests++; if (rc[1] !== 4) begin n_fail++; $display("FAIL b2b_count2: got %0d expected 4", rc[1]); end
        n_tests++; if (total_cnt !== 8'd7) begin n_fail++; $display("FAIL b2b_total: got %0d expected 7", total_cnt); end
    endtask

    // Three 0xAB words = 9 matches; the CNT_W=3 instance wraps or saturates.
    task automatic test_saturation();
        logic [2:0] exp3;
`ifdef SEQ_CTRL_SAT_EN
        exp3 = 3'd7;
`else
        exp3 = 3'd1;
`endif
        do_reset();
        for (int w = 0; w < 3; w++) begin
            run_word(8'hAB);
            tick();
        end
        n_tests++; if (total_cnt !== 8'd9) begin n_fail++; $display("FAIL sat_total8: got %0d expected 9", total_cnt); end
        n_tests++; if (total_cnt_3 !== exp3) begin n_fail++; $display("FAIL sat_total3: got %0d expected %0d", total_cnt_3, exp3); end
        n_tests++; if (res_count_3 !== 4'd3) begin n_fail++; $display("FAIL sat_res_count3: got %0d expected 3", res_count_3); end
    endtask

    // clr_total on the edge of the third match drops that increment.
    task automatic test_clear();
        do_reset();
        in_data  = 8'hAB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        n_tests++; if (total_cnt !== 8'd2) begin n_fail++; $display("FAIL clr_pre_total: got %0d expected 2", total_cnt); end
        clr_total = 1'b1;
        tick();
        clr_total = 1'b0;
        n_tests++; if (total_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_total_now: got %0d expected 0", total_cnt); end
        n_tests++; if (det_o !== 1'b1) begin n_fail++; $display("FAIL clr_det_o: got %b expected 1", det_o); end
        tick();
        n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL clr_res_valid: got %b expected 1", res_valid); end
        n_tests++; if (res_count !== 4'd3) begin n_fail++; $display("FAIL clr_res_count: got %0d expected 3", res_count); end
        n_tests++; if (total_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_total_after: got %0d expected 0", total_cnt); end
        tick();
    endtask

    // Reset during the 4th SHIFT cycle discards the word without a report.
    task automatic test_reset_mid();
        int rv_seen;
        do_reset();
        in_data  = 8'hAB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_tests++; if (det_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_det: got %b expected 1", det_o); end
        n_tests++; if (total_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_pre_total: got %0d expected 1", total_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_tests++; if (det_o !== 1'b0) begin n_fail++; $display("FAIL mid_det_o: got %b expected 0", det_o); end
        n_tests++; if (total_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_total: got %0d expected 0", total_cnt); end
        n_tests++; if (bit_o !== 1'b0) begin n_fail++; $display("FAIL mid_bit_o: got %b expected 0", bit_o); end
        rv_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (res_valid !== 1'b0) rv_seen++;
        end
        n_tests++; if (rv_seen !== 0) begin n_fail++; $display("FAIL mid_no_report: got %0d pulses expected 0", rv_seen); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        clr_total = 1'b0;
        test_reset();
        test_pattern_ab();
        test_boundary();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
